huffman_decoder: RTL and testbench
==================================

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low: clk input 1 (rising edge); reset input 1 (synchronous, active-low).
REQ-002 code_valid  input  1  one-cycle strobe; HC and M hold a valid code table this cycle.
REQ-003 HC  input  48  codewords, right-aligned; A1 in [47:40] through A6 in [7:0].
REQ-004 M  input  48  masks, same packing; each byte is contiguous ones from bit 0; popcount gives code length 1..8.
REQ-005 bit_valid  input  1  bit_in carries one stream bit this cycle.
REQ-006 bit_in  input  1  serial code bit, each codeword sent MSB first.
REQ-007 gray_valid  output  1  one-cycle pulse; gray_data carries a decoded symbol.
REQ-008 gray_data  output  8  decoded symbol index 1..6 (A1=1 ... A6=6).
REQ-009 err  output  1  one-cycle pulse; 8 bits accumulated with no codeword match.
REQ-010 CNT  output  48  per-symbol decode counts, same packing as HC, each byte saturating at 255.
REQ-011 ready  output  1  high while in DECODE state.

Function
REQ-012 States SHALL be IDLE and DECODE; reset enters IDLE; code_valid moves IDLE->DECODE; there is no transition back to IDLE except reset.
REQ-013 On code_valid the block SHALL latch HC and M into internal tables, clear shift register, length counter and CNT, in any state.
REQ-014 In IDLE, bit_valid SHALL be ignored (no shift, no output).
REQ-015 In DECODE, on bit_valid: sr <= {sr[6:0], bit_in}; len <= len+1 (len 0..8, 4-bit).
REQ-016 Match for symbol i SHALL mean M_i == (2^len_new - 1) and (sr_new & M_i) == HC_i, evaluated on the updated sr/len.
REQ-017 On match the block SHALL, on the next rising edge, assert gray_valid for 1 cycle with gray_data = i, clear sr and len, and increment CNT byte i unless it is 255.
REQ-018 Decode latency SHALL be 1 cycle: gray_valid is high in the cycle after the cycle in which the completing bit is sampled.
REQ-019 If several symbols match (non-prefix-free table), the lowest index SHALL win.
REQ-020 If len_new == 8 and no match, the block SHALL assert err for 1 cycle, clear sr and len, and leave CNT unchanged.
REQ-021 code_valid together with bit_valid in the same cycle SHALL perform the table load and discard the bit.
REQ-022 Bits SHALL be accepted back-to-back every cycle with no bubble after a decoded symbol.
REQ-023 gray_valid and err SHALL never be high in the same cycle; gray_data SHALL hold its last value when gray_valid is low.

Reset
REQ-024 With reset low at a rising edge, the block SHALL go to IDLE and set gray_valid=0, gray_data=0, err=0, CNT=0, ready=0, sr=0, len=0 and tables=0; reset low overrides code_valid and bit_valid.
REQ-025 Reset asserted mid-codeword SHALL discard the partial code; no gray_valid or err is produced for it.

Verification
Table T: HC=48'h01_01_01_01_01_00, M=48'h01_03_07_0F_1F_1F (A1="1", A2="01", A3="001", A4="0001", A5="00001", A6="00000").
REQ-026 Load T, then stream 1,01,001,0001,00001,00000 back-to-back -> gray_data 1,2,3,4,5,6, each pulse 1 cycle after its last bit; CNT=48'h01_01_01_01_01_01.
REQ-027 Bits before any code_valid -> no gray_valid and no err; ready=0 until the first load.
REQ-028 Load T with A6 changed to HC=01, M=3F; stream 00000000 -> err pulse after bit 8, no gray_valid; the next bit 1 -> gray_data=1.
REQ-029 Stream 300 codewords "1" -> CNT[47:40] saturates at 8'hFF, all other bytes 0.
REQ-030 Send "00" then code_valid together with bit_valid -> tables reloaded, CNT=0, partial code dropped; the next "1" -> gray_data=1.
REQ-031 Send "000" then reset low for 1 cycle -> all outputs 0, IDLE state; no decode occurs until code_valid.

Source files
------------

// File: rtl/huffman_decoder.sv
// -----------------------------------------------------------------------------
// huffman_decoder
//   Serial Huffman decoder for a six-symbol code table. A code table
//   (codewords HC plus contiguous masks M) is loaded with code_valid. In
//   DECODE the block shifts in one stream bit per bit_valid and compares the
//   accumulated bits against every table entry. A match emits the symbol
//   index on gray_data with a one-cycle gray_valid pulse. Eight bits without
//   a match produce a one-cycle err pulse. Per-symbol hit counters saturate
//   at 255.
//
// Handshake: there is no backpressure. A bit is consumed in every cycle in
//   which bit_valid is high and the block is in DECODE. gray_valid and err
//   are single-cycle strobes that appear in the cycle after the completing
//   bit is sampled.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   code_valid   load strobe for HC/M; clears sr, len and CNT
//   HC[47:0]     codewords, right-aligned bytes, A1 in [47:40] .. A6 in [7:0]
//   M[47:0]      masks, same packing, contiguous ones from bit 0
//   bit_valid    bit_in carries a stream bit this cycle
//   bit_in       serial code bit, MSB of each codeword first
//   gray_valid   one-cycle pulse, gray_data holds a decoded symbol
//   gray_data    decoded symbol index 1..6, held between pulses
//   err          one-cycle pulse, 8 bits accumulated with no match
//   CNT[47:0]    per-symbol saturating decode counts, same packing as HC
//   ready        high while in DECODE
//   dbg_state_o  current FSM state (0 = IDLE, 1 = DECODE)
// -----------------------------------------------------------------------------
module huffman_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [47:0] HC,
  input  logic [47:0] M,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        gray_valid,
  output logic [7:0]  gray_data,
  output logic        err,
  output logic [47:0] CNT,
  output logic        ready,
  output logic        dbg_state_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    DECODE = 1'b1
  } state_e;

  state_e      state_q;
  logic [47:0] hc_q;
  logic [47:0] m_q;
  logic [7:0]  sr_q;
  logic [3:0]  len_q;
  logic        gray_valid_q;
  logic [7:0]  gray_data_q;
  logic        err_q;
  logic [47:0] cnt_q;

  // Candidate shift-register state after accepting bit_in this cycle.
  logic [7:0]  sr_d;
  logic [3:0]  len_d;
  logic [7:0]  mask_d;
  logic        hit;
  logic [2:0]  hit_idx;
  logic [47:0] cnt_d;

  always_comb begin
    sr_d    = {sr_q[6:0], bit_in};
    len_d   = len_q + 4'd1;
    // len_d is 1..8 whenever a bit is accepted, so this is 2^len_d - 1.
    mask_d  = 8'((9'd1 << len_d) - 9'd1);
    hit     = 1'b0;
    hit_idx = 3'd0;
    // Byte 8*i holds symbol 6-i. Scanning upward lets the lowest symbol
    // index overwrite any higher one, which resolves non-prefix-free tables.
    for (int i = 0; i < 6; i++) begin
      if ((m_q[8*i +: 8] == mask_d) &&
          ((sr_d & m_q[8*i +: 8]) == hc_q[8*i +: 8])) begin
        hit     = 1'b1;
        hit_idx = 3'(6 - i);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 6; i++) begin
      if (hit && (hit_idx == 3'(6 - i)) && (cnt_q[8*i +: 8] != 8'hFF)) begin
        cnt_d[8*i +: 8] = cnt_q[8*i +: 8] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hc_q         <= '0;
      m_q          <= '0;
      sr_q         <= '0;
      len_q        <= '0;
      gray_valid_q <= 1'b0;
      gray_data_q  <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      gray_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (code_valid) begin
        // A table load wins over a coincident bit; that bit is dropped.
        state_q <= DECODE;
        hc_q    <= HC;
        m_q     <= M;
        sr_q    <= '0;
        len_q   <= '0;
        cnt_q   <= '0;
      end else if ((state_q == DECODE) && bit_valid) begin
        if (hit) begin
          gray_valid_q <= 1'b1;
          gray_data_q  <= {5'd0, hit_idx};
          sr_q         <= '0;
          len_q        <= '0;
          cnt_q        <= cnt_d;
        end else if (len_d == 4'd8) begin
          err_q <= 1'b1;
          sr_q  <= '0;
          len_q <= '0;
        end else begin
          sr_q  <= sr_d;
          len_q <= len_d;
        end
      end
    end
  end

  assign gray_valid  = gray_valid_q;
  assign gray_data   = gray_data_q;
  assign err         = err_q;
  assign CNT         = cnt_q;
  assign ready       = (state_q == DECODE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// -----------------------------------------------------------------------------
// tb_huffman_decoder
//   Bench for huffman_decoder. A bit-list reference model predicts every
//   gray_valid/err event (with the cycle it must appear in) and the per-symbol
//   counts. A negedge monitor pops predicted events from exp_q. Hand-written
//   sequences cover the table-T walk-through, the error path, saturation,
//   load-with-bit and reset mid-codeword. Randomized tables and streams
//   follow.
// -----------------------------------------------------------------------------
module tb_huffman_decoder;

  logic        clk;
  logic        reset;
  logic        code_valid;
  logic [47:0] HC;
  logic [47:0] M;
  logic        bit_valid;
  logic        bit_in;
  logic        gray_valid;
  logic [7:0]  gray_data;
  logic        err;
  logic [47:0] CNT;
  logic        ready;
  logic        dbg_state_o;

  huffman_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC         (HC),
    .M          (M),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .err        (err),
    .CNT        (CNT),
    .ready      (ready),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   cyc = 0;
  logic rst_s = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
  end

  // ---------------- counters / check ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected events: {cycle[15:0], err, gray_valid, symbol[7:0]}.
  logic [25:0] exp_q[$];
  bit          bits_q[$];
  logic [47:0] t_hc;
  logic [47:0] t_m;
  bit          loaded;
  int          cnt_m[1:6];

  task automatic model_clear_counts();
    for (int i = 1; i <= 6; i++) cnt_m[i] = 0;
  endtask

  function automatic logic [47:0] cnt_pack();
    logic [47:0] r;
    r = '0;
    for (int i = 1; i <= 6; i++) r[48-8*i +: 8] = 8'(cnt_m[i]);
    return r;
  endfunction

  // Append a bit to the pending codeword; the codeword is the list of bits
  // received so far, read as a binary number. Symbol i matches when its mask
  // has exactly as many ones as bits received and the masked value equals HC_i.
  task automatic model_bit(input bit b);
    int n;
    int val;
    int win;
    int mi;
    int hi;
    if (!loaded) return;
    bits_q.push_back(b);
    n   = bits_q.size();
    val = 0;
    foreach (bits_q[k]) val = val * 2 + int'(bits_q[k]);
    win = 0;
    for (int i = 1; i <= 6 && win == 0; i++) begin
      mi = int'(t_m[48-8*i +: 8]);
      hi = int'(t_hc[48-8*i +: 8]);
      if (mi == (1 << n) - 1 && (val & mi) == hi) win = i;
    end
    if (win != 0) begin
      if (cnt_m[win] < 255) cnt_m[win]++;
      bits_q.delete();
      exp_q.push_back({16'(cyc + 1), 1'b0, 1'b1, 8'(win)});
    end else if (n == 8) begin
      bits_q.delete();
      exp_q.push_back({16'(cyc + 1), 1'b1, 1'b0, 8'd0});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          mon_en = 1'b0;
  logic [7:0]  mon_last_gd = 8'd0;
  logic [25:0] mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_s) begin
        mon_last_gd = 8'd0;
        check("rst_gray_valid", {63'd0, gray_valid}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_gray_data", {56'd0, gray_data}, 64'd0);
        check("rst_cnt", {16'd0, CNT}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
      end else if (gray_valid || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {46'd0, 16'(cyc), err, gray_valid}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("event", {38'd0, 16'(cyc), err, gray_valid, gray_valid ? gray_data : 8'd0},
                {38'd0, mon_e});
          if (mon_e[8]) mon_last_gd = mon_e[7:0];
        end
      end else begin
        check("gray_data_hold", {56'd0, gray_data}, {56'd0, mon_last_gd});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    code_valid = 1'b0;
    bit_valid  = 1'b0;
    loaded     = 1'b0;
    bits_q.delete();
    model_clear_counts();
    step();
    reset = 1'b1;
  endtask

  task automatic load(input logic [47:0] hc, input logic [47:0] m, input bit with_bit, input bit b);
    code_valid = 1'b1;
    HC         = hc;
    M          = m;
    bit_valid  = with_bit;
    bit_in     = b;
    t_hc       = hc;
    t_m        = m;
    loaded     = 1'b1;
    bits_q.delete();
    model_clear_counts();
    step();
    code_valid = 1'b0;
    bit_valid  = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    bit_valid = 1'b1;
    bit_in    = b;
    model_bit(b);
    step();
    bit_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    bit_valid = 1'b0;
    bit_in    = 1'($urandom_range(0, 1));
    step();
  endtask

  // ---------------- vectors ----------------
  localparam logic [47:0] T_HC  = 48'h01_01_01_01_01_00;
  localparam logic [47:0] T_M   = 48'h01_03_07_0F_1F_1F;
  localparam logic [47:0] T2_HC = 48'h01_01_01_01_01_01;
  localparam logic [47:0] T2_M  = 48'h01_03_07_0F_1F_3F;

  typedef struct {
    int         n;
    logic [7:0] code;
    logic [7:0] exp_sym;
  } vec_t;

  vec_t vt[6];

  logic [47:0] r_hc;
  logic [47:0] r_m;
  int          r_len;
  int          r;
  logic [7:0]  mb;
  logic [7:0]  hb;

  initial begin
    reset      = 1'b0;
    code_valid = 1'b0;
    HC         = '0;
    M          = '0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    loaded     = 1'b0;
    model_clear_counts();

    vt[0] = '{1, 8'b1,     8'd1};
    vt[1] = '{2, 8'b01,    8'd2};
    vt[2] = '{3, 8'b001,   8'd3};
    vt[3] = '{4, 8'b0001,  8'd4};
    vt[4] = '{5, 8'b00001, 8'd5};
    vt[5] = '{5, 8'b00000, 8'd6};

    repeat (2) step();
    do_reset();
    mon_en = 1'b1;
    check("reset_state", {63'd0, dbg_state_o}, 64'd0);

    // Bits before any load are ignored.
    for (int k = 0; k < 10; k++) send_bit(1'($urandom_range(0, 1)));
    check("preload_ready", {63'd0, ready}, 64'd0);
    check("preload_state", {63'd0, dbg_state_o}, 64'd0);

    // Table T walk-through, back-to-back codewords.
    load(T_HC, T_M, 1'b0, 1'b0);
    check("load_ready", {63'd0, ready}, 64'd1);
    check("load_state", {63'd0, dbg_state_o}, 64'd1);
    for (int v = 0; v < 6; v++) begin
      for (int k = vt[v].n - 1; k >= 0; k--) send_bit(vt[v].code[k]);
      check("vec_gray_valid", {63'd0, gray_valid}, 64'd1);
      check("vec_gray_data", {56'd0, gray_data}, {56'd0, vt[v].exp_sym});
    end
    check("vec_cnt", {16'd0, CNT}, {16'd0, 48'h01_01_01_01_01_01});

    // No-match error after 8 bits, then recovery.
    load(T2_HC, T2_M, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) send_bit(1'b0);
    check("err_not_early", {63'd0, err}, 64'd0);
    send_bit(1'b0);
    check("err_pulse", {63'd0, err}, 64'd1);
    check("err_no_gray", {63'd0, gray_valid}, 64'd0);
    send_bit(1'b1);
    check("after_err_gray_valid", {63'd0, gray_valid}, 64'd1);
    check("after_err_gray_data", {56'd0, gray_data}, 64'd1);
    check("after_err_cnt", {16'd0, CNT}, {16'd0, 48'h01_00_00_00_00_00});

    // Saturation of the A1 counter.
    load(T_HC, T_M, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) send_bit(1'b1);
    check("sat_cnt", {16'd0, CNT}, {16'd0, 48'hFF_00_00_00_00_00});

    // Load together with a bit: the bit is discarded and the partial "00"
    // dropped, otherwise "001" would decode as A3.
    send_bit(1'b0);
    send_bit(1'b0);
    load(T_HC, T_M, 1'b1, 1'b1);
    check("ldbit_cnt", {16'd0, CNT}, 64'd0);
    check("ldbit_no_gray", {63'd0, gray_valid}, 64'd0);
    send_bit(1'b1);
    check("ldbit_gray_valid", {63'd0, gray_valid}, 64'd1);
    check("ldbit_gray_data", {56'd0, gray_data}, 64'd1);

    // Reset mid-codeword.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    do_reset();
    check("midrst_gray_data", {56'd0, gray_data}, 64'd0);
    check("midrst_cnt", {16'd0, CNT}, 64'd0);
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_state", {63'd0, dbg_state_o}, 64'd0);
    for (int k = 0; k < 6; k++) send_bit(1'b1);
    check("midrst_no_decode", {63'd0, gray_valid}, 64'd0);
    load(T_HC, T_M, 1'b0, 1'b0);
    send_bit(1'b1);
    check("midrst_reload_gd", {56'd0, gray_data}, 64'd1);

    // Randomized tables (often non-prefix-free) and streams.
    for (int t = 0; t < 6; t++) begin
      r_hc = '0;
      r_m  = '0;
      for (int i = 1; i <= 6; i++) begin
        r_len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 8));
        mb = 8'((9'd1 << r_len) - 9'd1);
        hb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) hb = hb & mb;
        r_hc[48-8*i +: 8] = hb;
        r_m[48-8*i +: 8]  = mb;
      end
      if (t == 0) begin
        r_hc = T_HC;
        r_m  = T_M;
      end
      load(r_hc, r_m, 1'b0, 1'b0);
      for (int k = 0; k < 400; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 3)       load(r_hc, r_m, 1'b1, 1'($urandom_range(0, 1)));
        else if (r < 12) idle_cycle();
        else             send_bit(1'($urandom_range(0, 1)));
      end
      repeat (2) step();
      check("rand_cnt", {16'd0, CNT}, {16'd0, cnt_pack()});
      check("rand_drained", 64'(exp_q.size()), 64'd0);
    end

    repeat (3) step();
    check("final_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
